// File: rtl/ram_scan_reader_if.sv
// ============================================================================
// ram_scan_reader_if : control, RAM-read and display bundle for ram_scan_reader
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_scan_reader_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  loop;
  logic                  pause;
  logic [DATA_WIDTH-1:0] q;
  logic [ADDR_WIDTH-1:0] rdaddress;
  logic [ADDR_WIDTH-1:0] disp_addr;
  logic [DATA_WIDTH-1:0] disp_data;
  logic                  valid;
  logic                  busy;
  logic                  done;

  // master: the board/RAM side that commands the scan and returns read data
  modport master (
    output start, loop, pause, q,
    input  rdaddress, disp_addr, disp_data, valid, busy, done
  );

  modport slave (
    input  start, loop, pause, q,
    output rdaddress, disp_addr, disp_data, valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/ram_scan_reader.sv
// ============================================================================
// ram_scan_reader : walks RAM addresses 0..max, captures each word and holds it
// for display. Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_scan_reader #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int HOLD_CYCLES  = 50000000
) (
  input  wire logic         clock,
  input  wire logic         reset,
  ram_scan_reader_if.slave  bus
);

  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [WAIT_W-1:0]     c_wait_init = WAIT_W'(READ_LATENCY - 1);
  localparam logic [HOLD_W-1:0]     c_hold_init = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_max  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [ADDR_WIDTH-1:0] r_rdaddress;
  logic [ADDR_WIDTH-1:0] r_disp_addr;
  logic [DATA_WIDTH-1:0] r_disp_data;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_rdaddress <= '0;
      r_disp_addr <= '0;
      r_disp_data <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rdaddress <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= c_wait_init;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // pause is deliberately not looked at here: capture is never delayed
          if (r_wait_cnt == '0) begin
            r_disp_data <= bus.q;
            r_disp_addr <= r_rdaddress;
            r_valid     <= 1'b1;
            r_hold_cnt  <= c_hold_init;
            r_state     <= S_HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
          end
        end
        S_HOLD: begin
          if (!bus.pause) begin
            if (r_hold_cnt == '0) begin
              if (r_rdaddress != c_addr_max) begin
                r_rdaddress <= r_rdaddress + ADDR_WIDTH'(1);
                r_state     <= S_ISSUE;
              end else if (bus.loop) begin
                r_rdaddress <= '0;
                r_state     <= S_ISSUE;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rdaddress = r_rdaddress;
  assign bus.disp_addr = r_disp_addr;
  assign bus.disp_data = r_disp_data;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ram_scan_reader.sv
// ============================================================================
// tb_ram_scan_reader : directed bench, RL=1 and RL=2 instances with RAM models
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_scan_reader;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int HC = 4;

  logic clock = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  ram_scan_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();
  ram_scan_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b2 ();

  ram_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .HOLD_CYCLES(HC))
    dut1 (.clock(clock), .reset(reset), .bus(b1));
  ram_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .HOLD_CYCLES(HC))
    dut2 (.clock(clock), .reset(reset), .bus(b2));

  // RAM contents mem[i] = 3i+1, read latency 1 for dut1 and 2 for dut2
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return DW'(3 * int'(a) + 1);
  endfunction

  logic [DW-1:0] r1_q, r2_s1, r2_q;
  always @(posedge clock) begin
    r1_q  <= ram_word(b1.rdaddress);
    r2_s1 <= ram_word(b2.rdaddress);
    r2_q  <= r2_s1;
  end
  assign b1.q = r1_q;
  assign b2.q = r2_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    b1.start = 1'b0; b1.loop = 1'b0; b1.pause = 1'b0;
    b2.start = 1'b0; b2.loop = 1'b0; b2.pause = 1'b0;
    cyc(3);
    check("rst_rdaddr", 32'(b1.rdaddress), 0);
    check("rst_dispaddr", 32'(b1.disp_addr), 0);
    check("rst_dispdata", 32'(b1.disp_data), 0);
    check("rst_valid", 32'(b1.valid), 0);
    check("rst_busy", 32'(b1.busy), 0);
    check("rst_done", 32'(b1.done), 0);
    check("rst_busy2", 32'(b2.busy), 0);
    reset = 1'b0;
    cyc(1);

    // ---- non-loop scan, RL=1; extra start pulse while showing addr 10
    b1.start = 1'b1;
    cyc(1);
    b1.start = 1'b0;
    check("c1_busy", 32'(b1.busy), 1);
    check("c1_rdaddr", 32'(b1.rdaddress), 0);
    cyc(1);
    check("c2_valid", 32'(b1.valid), 0);
    cyc(1);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("s1_addr%0d", i), 32'(b1.disp_addr), 32'(i));
      check($sformatf("s1_data%0d", i), 32'(b1.disp_data), 32'(3 * i + 1));
      check($sformatf("s1_valid%0d", i), 32'(b1.valid), 1);
      if (i < 31) begin
        if (i == 10) begin
          b1.start = 1'b1;
          cyc(1);
          b1.start = 1'b0;
          cyc(4);
        end else begin
          cyc(5);
        end
        check($sformatf("s1_hold_addr%0d", i), 32'(b1.disp_addr), 32'(i));
        check($sformatf("s1_hold_data%0d", i), 32'(b1.disp_data), 32'(3 * i + 1));
        check($sformatf("s1_next_rd%0d", i), 32'(b1.rdaddress), 32'(i + 1));
        cyc(1);
      end
    end
    cyc(3);  // cycle 192
    check("c192_done", 32'(b1.done), 0);
    check("c192_busy", 32'(b1.busy), 1);
    cyc(1);  // cycle 193
    check("c193_done", 32'(b1.done), 1);
    check("c193_busy", 32'(b1.busy), 1);
    cyc(1);  // cycle 194
    check("c194_done", 32'(b1.done), 0);
    check("c194_busy", 32'(b1.busy), 0);
    check("c194_valid", 32'(b1.valid), 1);
    check("c194_addr", 32'(b1.disp_addr), 31);
    check("c194_data", 32'(b1.disp_data), 32'h5E);

    // ---- loop scan with pause on second lap, then reset mid-WAIT
    b1.loop  = 1'b1;
    b1.start = 1'b1;
    cyc(1);
    b1.start = 1'b0;
    cyc(188);  // cycle 189
    check("lp_addr31", 32'(b1.disp_addr), 31);
    check("lp_data31", 32'(b1.disp_data), 32'h5E);
    cyc(4);    // cycle 193
    check("lp_nodone", 32'(b1.done), 0);
    check("lp_busy", 32'(b1.busy), 1);
    check("lp_wrap_rd", 32'(b1.rdaddress), 0);
    cyc(2);    // cycle 195
    check("lp_addr0", 32'(b1.disp_addr), 0);
    check("lp_data0", 32'(b1.disp_data), 32'h01);
    check("lp_valid", 32'(b1.valid), 1);
    cyc(30);   // cycle 225, addr 5 enters HOLD
    check("p_addr5", 32'(b1.disp_addr), 5);
    check("p_data5", 32'(b1.disp_data), 32'h10);
    cyc(1);
    b1.pause = 1'b1;
    cyc(10);   // cycle 236
    b1.pause = 1'b0;
    check("p_frozen_rd", 32'(b1.rdaddress), 5);
    cyc(2);    // cycle 238, last HOLD cycle
    check("p_last_hold_rd", 32'(b1.rdaddress), 5);
    check("p_last_hold_addr", 32'(b1.disp_addr), 5);
    cyc(1);    // cycle 239, ISSUE addr 6
    check("p_issue6_rd", 32'(b1.rdaddress), 6);
    cyc(1);    // cycle 240, WAIT addr 6
    b1.pause = 1'b1;
    cyc(1);    // cycle 241
    b1.pause = 1'b0;
    check("pw_addr6", 32'(b1.disp_addr), 6);
    check("pw_data6", 32'(b1.disp_data), 32'h13);
    cyc(4);    // cycle 245, ISSUE addr 7
    check("r_issue7_rd", 32'(b1.rdaddress), 7);
    cyc(1);    // cycle 246, WAIT addr 7
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("mr_rdaddr", 32'(b1.rdaddress), 0);
    check("mr_dispaddr", 32'(b1.disp_addr), 0);
    check("mr_dispdata", 32'(b1.disp_data), 0);
    check("mr_valid", 32'(b1.valid), 0);
    check("mr_busy", 32'(b1.busy), 0);
    check("mr_done", 32'(b1.done), 0);
    b1.loop = 1'b0;
    cyc(1);
    check("mr_idle_busy", 32'(b1.busy), 0);
    check("mr_idle_valid", 32'(b1.valid), 0);
    b1.start = 1'b1;
    cyc(1);
    b1.start = 1'b0;
    cyc(2);
    check("rs_addr0", 32'(b1.disp_addr), 0);
    check("rs_data0", 32'(b1.disp_data), 32'h01);
    check("rs_valid", 32'(b1.valid), 1);

    // ---- RL=2 instance: first capture cycle 4, period 7
    b2.start = 1'b1;
    cyc(1);
    b2.start = 1'b0;
    cyc(2);    // cycle 3
    check("l2_c3_valid", 32'(b2.valid), 0);
    cyc(1);    // cycle 4
    for (int i = 0; i < 32; i++) begin
      check($sformatf("l2_addr%0d", i), 32'(b2.disp_addr), 32'(i));
      check($sformatf("l2_data%0d", i), 32'(b2.disp_data), 32'(3 * i + 1));
      check($sformatf("l2_valid%0d", i), 32'(b2.valid), 1);
      if (i < 31) cyc(7);
    end
    cyc(3);    // cycle 224
    check("l2_c224_done", 32'(b2.done), 0);
    cyc(1);    // cycle 225
    check("l2_c225_done", 32'(b2.done), 1);
    check("l2_c225_busy", 32'(b2.busy), 1);
    cyc(1);    // cycle 226
    check("l2_c226_busy", 32'(b2.busy), 0);
    check("l2_c226_data", 32'(b2.disp_data), 32'h5E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
